// File: rtl/std_seq_mult_6_if.sv
// Operand/result bundle for the sequential shift-add multiplier.
// The master drives operands and go; the slave returns the product and status.
interface std_seq_mult_6_if #(
  parameter int WIDTH = 6
);
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             go;
  logic [WIDTH-1:0] out;
  logic             done;
  logic             busy;

  modport master (output left, right, go, input out, done, busy);
  modport slave  (input left, right, go, output out, done, busy);
endinterface

// File: rtl/std_seq_mult_6.sv
// Sequential shift-add multiplier: one partial product per BUSY cycle.
// Returns (left*right) mod 2^WIDTH with a one-cycle done pulse.
module std_seq_mult_6 #(
  parameter int WIDTH = 6
) (
  input logic            clk,
  input logic            reset,
  std_seq_mult_6_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_r;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] out_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;
  logic             busy_r;

  logic [WIDTH-1:0] step_idx_s;
  logic [WIDTH-1:0] addend_s;
  logic [WIDTH-1:0] sum_s;

  // Partial product for the current step; the shift amount is the step index.
  always_comb begin
    step_idx_s = WIDTH'(CNT_INIT - cnt_r);
    addend_s   = {WIDTH{1'b0}};
    if (mplier_r[0]) begin
      addend_s = mcand_r << step_idx_s;
    end else begin
      addend_s = {WIDTH{1'b0}};
    end
    sum_s = acc_r + addend_s;
  end

  // Control FSM and datapath registers; out only loads the final sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      out_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.go) begin
            mcand_r  <= bus.left;
            mplier_r <= bus.right;
            acc_r    <= {WIDTH{1'b0}};
            cnt_r    <= CNT_INIT;
            busy_r   <= 1'b1;
            state_r  <= BUSY;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        BUSY: begin
          acc_r    <= sum_s;
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          cnt_r    <= cnt_r - CNT_ONE;
          busy_r   <= 1'b1;
          if (cnt_r == CNT_ONE) begin
            out_r   <= sum_s;
            done_r  <= 1'b1;
            state_r <= DONE;
          end else begin
            done_r  <= 1'b0;
            state_r <= BUSY;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.out  = out_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;
endmodule

// File: tb/tb_std_seq_mult_6.sv
// Directed bench for std_seq_mult_6 with a downstream register model on out/done.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_std_seq_mult_6;
  localparam int WIDTH = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  std_seq_mult_6_if #(.WIDTH(WIDTH)) bus ();
  std_seq_mult_6 #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] last_out = 6'd0;

  // Downstream std_reg: captures out when write_en (done) is high, done one cycle later.
  logic [WIDTH-1:0] reg_out;
  logic             reg_done;
  always @(posedge clk) begin
    if (reset) begin
      reg_out  <= 6'd0;
      reg_done <= 1'b0;
    end else if (bus.done) begin
      reg_out  <= bus.out;
      reg_done <= 1'b1;
    end else begin
      reg_done <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start with (l, r), swap operands to (l2, r2) and drop go after the start edge.
  task automatic run_op(input string tag, input logic [5:0] l, input logic [5:0] r,
                        input logic [5:0] l2, input logic [5:0] r2, input logic [5:0] exp);
    int  cyc;
    bit  seen;
    bus.left  = l;
    bus.right = r;
    bus.go    = 1'b1;
    tick();
    bus.go    = 1'b0;
    bus.left  = l2;
    bus.right = r2;
    check({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    check({tag, "_out_hold"}, 32'(bus.out), 32'(last_out));
    cyc  = 1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      cyc++;
      seen = bus.done;
    end
    check({tag, "_latency"}, seen ? 32'(cyc) : 32'd0, 32'd7);
    check({tag, "_out"}, 32'(bus.out), 32'(exp));
    check({tag, "_busy_done"}, 32'(bus.busy), 32'd1);
    check({tag, "_reg_done_early"}, 32'(reg_done), 32'd0);
    tick();
    check({tag, "_done_low"}, 32'(bus.done), 32'd0);
    check({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
    check({tag, "_reg_done"}, 32'(reg_done), 32'd1);
    check({tag, "_reg_out"}, 32'(reg_out), 32'(exp));
    last_out = exp;
  endtask

  initial begin
    int  pulses;
    int  last_t;
    bit  prev_done;
    bit  seen;

    reset     = 1'b1;
    bus.go    = 1'b0;
    bus.left  = 6'd0;
    bus.right = 6'd0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out", 32'(bus.out), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);

    run_op("m5x7",   6'd5,  6'd7,  6'd5,  6'd7,  6'd35);
    run_op("m63x63", 6'd63, 6'd63, 6'd0,  6'd0,  6'd1);
    run_op("m0x45",  6'd0,  6'd45, 6'd45, 6'd0,  6'd0);
    run_op("m45x0",  6'd45, 6'd0,  6'd0,  6'd45, 6'd0);
    run_op("m1x63",  6'd1,  6'd63, 6'd2,  6'd2,  6'd63);
    run_op("m13x11", 6'd13, 6'd11, 6'd63, 6'd63, 6'd15);

    // Idle with go low: operands change, nothing else should.
    bus.left  = 6'd9;
    bus.right = 6'd9;
    for (int i = 0; i < 4; i++) tick();
    check("idle_out", 32'(bus.out), 32'd15);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // go held high: back-to-back operations, done every WIDTH+2 cycles.
    bus.left  = 6'd3;
    bus.right = 6'd4;
    bus.go    = 1'b1;
    pulses    = 0;
    last_t    = 0;
    prev_done = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (bus.done) begin
        check("held_out", 32'(bus.out), 32'd12);
        check("held_busy", 32'(bus.busy), 32'd1);
        if (pulses > 0) check("held_spacing", 32'(t - last_t), 32'd8);
        if (prev_done) check("held_consecutive", 32'd1, 32'd0);
        last_t = t;
        pulses++;
      end
      prev_done = bus.done;
    end
    check("held_pulses", 32'(pulses), 32'd3);
    bus.go = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    last_out = 6'd12;

    // Reset during the third BUSY cycle aborts without a done pulse.
    bus.left  = 6'd9;
    bus.right = 6'd9;
    bus.go    = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_out", 32'(bus.out), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen = seen | bus.done;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    check("abort_out_later", 32'(bus.out), 32'd0);
    last_out = 6'd0;
    run_op("restart", 6'd2, 6'd3, 6'd2, 6'd3, 6'd6);

    // Operands changed after the start edge must not leak into the result.
    run_op("m2x5", 6'd2, 6'd5, 6'd7, 6'd7, 6'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
